pcie_rx_tlp_decoder: RTL
========================

// Module: pcie_rx_tlp_decoder
// PURPOSE
//  Consumes the 64-bit AXI4-Stream RX interface (m_axis_rx_*) of the K7 PCIe endpoint wrapper.
//  Decodes single-DW memory requests to one BAR into a register write port and a read-request port.
//  The read-request port feeds the completion generator.
//  Every other TLP is drained and counted; rx_np_ok throttles non-posted traffic while a read is outstanding.
// PARAMETERS
//  ADDR_W     10  DW-address width inside the BAR; wr_addr/rd_addr = byte_addr[ADDR_W+1:2]
//  BAR_INDEX  0   accepted BAR; hit when m_axis_rx_tuser[2+BAR_INDEX]==1
//  CNT_W      16  width of the saturating drop counter
// PORTS
//  user_clk          in   1       endpoint user clock (user_clk_out)
//  user_rst_n        in   1       async active-low reset
//  m_axis_rx_tdata   in   64      RX beat; DW0 in [31:0], DW1 in [63:32]
//  m_axis_rx_tkeep   in   8       byte enables of beat (only ignored-beat checking)
//  m_axis_rx_tlast   in   1       last beat of TLP
//  m_axis_rx_tvalid  in   1       beat valid
//  m_axis_rx_tready  out  1       beat accepted when tvalid&tready
//  m_axis_rx_tuser   in   22      [8:2] BAR hit, [1] error-forward
//  rx_np_ok          out  1       1 = endpoint may deliver non-posted TLPs
//  wr_valid/wr_ready out/in 1     register-write handshake
//  wr_addr           out  ADDR_W  DW address
//  wr_data           out  32      payload DW, byte order as received
//  wr_be             out  4       first-DW byte enables
//  rd_valid/rd_ready out/in 1     read-request handshake to completer
//  rd_addr           out  ADDR_W  DW address
//  rd_req_id         out  16      requester ID
//  rd_tag            out  8       tag
//  rd_tc             out  3       traffic class
//  rd_attr           out  2       attributes
//  rd_be             out  4       first-DW byte enables
//  rd_lower_addr     out  7       byte_addr[6:2],2'b00 derived from first BE, for completion header
//  drop_cnt          out  CNT_W   saturating count of discarded TLPs
// BEHAVIOUR
//  Reset (async, user_rst_n=0)
//   - State S_HDR0; all outputs 0, except m_axis_rx_tready=1 and rx_np_ok=1.
//   - Reset mid-TLP abandons it; the remainder is seen after reset as a malformed start beat.
//  Header field decode
//   - DW0: fmt=[30:29], type=[28:24], tc=[22:20], attr=[13:12], length=[9:0].
//   - DW1: req_id=[31:16], tag=[15:8], last_be=[7:4], first_be=[3:0].
//  Accepted TLPs
//   - MRd32 (fmt 00), MWr32 (fmt 10), MRd64 (fmt 01), MWr64 (fmt 11), type 00000.
//   - length==1, last_be==0, BAR hit, tuser[1]==0.
//   - Anything else is "unsupported": go to S_DRAIN (or stay in S_HDR0 if tlast), drop_cnt+1, saturate at all-ones.
//  States (beat consumed only on tvalid&tready)
//   - S_HDR0: latch DW0/DW1, classify, go to S_HDR1. If tlast on this beat, treat as malformed and drop.
//   - S_HDR1: 3DW TLP: DW2=address, DW3=payload (MWr32) or ignored (MRd32); must be tlast, else S_DRAIN+drop.
//     4DW TLP: DW2=addr hi (ignored), DW3=addr lo. MRd64 must be tlast. MWr64 goes to S_DATA.
//   - S_DATA: DW0 of beat = payload; tkeep[7:4] ignored; must be tlast, else S_DRAIN+drop.
//   - S_DRAIN: tready=1; discard until tlast beat, then S_HDR0.
//   - S_WR: wr_valid=1, tready=0. On wr_ready go to S_HDR0 (tready=1 next cycle).
//   - S_RD: rd_valid=1, tready=0, rx_np_ok=0. On rd_ready go to S_HDR0; rx_np_ok returns to 1 next cycle.
//  Latency and handshake rules
//   - Registered outputs: wr_valid/rd_valid assert the cycle after the final TLP beat is accepted.
//   - Payload fields are stable while valid is high.
//   - Valid never drops without ready; one transaction at a time; no wr/rd overlap.
//   - Back-to-back TLPs: minimum 1 idle tready=0 cycle per accepted request; dropped TLPs cost no extra cycles.
//  Arithmetic
//   - rd_lower_addr[1:0] is the index of the lowest set bit of first_be (00 if first_be==0).
//   - drop_cnt never wraps.
// TESTING
//  1. MWr32 BAR0 addr 0x0000_0010, data 0xDEADBEEF, BE 0xF -> wr_valid next cycle, wr_addr=4, wr_data=0xDEADBEEF, wr_be=F.
//  2. MRd32 tag 0x2A, req_id 0x0100, addr 0x24, BE 0xC -> rd_valid, rd_addr=9, rd_tag=2A, rd_lower_addr=0x26.
//     Check rx_np_ok=0 until rd_ready; hold rd_ready low 20 cycles and check fields stable, tready=0.
//  3. MWr64 addr hi 0x1, lo 0x08, data 0x12345678 -> 3 beats consumed, wr_addr=2, upper address ignored.
//  4. MWr32 length=4, then BAR1 hit, then Msg TLP -> all drained to tlast, no wr/rd valid, drop_cnt=3.
//  5. Preload drop_cnt to all-ones-1, drop 2 TLPs -> drop_cnt=all-ones.
//     Assert user_rst_n mid-S_WR -> wr_valid=0 immediately, tready=1.

Source files
------------

// File: rtl/pcie_rx_tlp_decoder.sv
// pcie_rx_tlp_decoder
//   Consumes the 64-bit AXI4-Stream RX interface of the K7 PCIe endpoint and
//   decodes single-DW memory requests (MRd/MWr, 32- and 64-bit addressing)
//   to one BAR. Each request becomes either a register write (wr_*) or a
//   read request for the completion generator (rd_*). Every other TLP is
//   drained to tlast and counted in a saturating drop counter. rx_np_ok is
//   deasserted while a read request is waiting to be accepted.
//
// Ports
//   user_clk, user_rst_n   clock, asynchronous active-low reset
//   m_axis_rx_*            RX beat stream (DW0 in [31:0], DW1 in [63:32]),
//                          tuser[8:2] BAR hit, tuser[1] error-forward
//   rx_np_ok               1 = endpoint may deliver non-posted TLPs
//   wr_valid/wr_ready      register write: wr_addr (DW), wr_data, wr_be
//   rd_valid/rd_ready      read request: rd_addr (DW), requester ID, tag,
//                          tc, attr, first BE, lower address for completion
//   drop_cnt               saturating count of discarded TLPs
module pcie_rx_tlp_decoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BAR_INDEX = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [63:0]       m_axis_rx_tdata,
  input  logic [7:0]        m_axis_rx_tkeep,
  input  logic              m_axis_rx_tlast,
  input  logic              m_axis_rx_tvalid,
  output logic              m_axis_rx_tready,
  input  logic [21:0]       m_axis_rx_tuser,
  output logic              rx_np_ok,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_req_id,
  output logic [7:0]        rd_tag,
  output logic [2:0]        rd_tc,
  output logic [1:0]        rd_attr,
  output logic [3:0]        rd_be,
  output logic [6:0]        rd_lower_addr,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DRAIN,
    S_WR,
    S_RD
  } state_t;

  state_t state, next_state;

  logic        beat;
  logic        drop;
  logic [31:0] dw0, dw1;
  logic        hdr_ok;

  logic        is_wr_q;
  logic        is_4dw_q;
  logic [15:0] req_id_q;
  logic [7:0]  tag_q;
  logic [2:0]  tc_q;
  logic [1:0]  attr_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  be_low;

  assign beat = m_axis_rx_tvalid & m_axis_rx_tready;
  assign dw0  = m_axis_rx_tdata[31:0];
  assign dw1  = m_axis_rx_tdata[63:32];

  // Header-beat classification: MRd/MWr 32/64 (any fmt with type 0), one DW,
  // no last BE, our BAR hit, not poisoned.
  assign hdr_ok = (dw0[28:24] == 5'b00000) && (dw0[9:0] == 10'd1) &&
                  (dw1[7:4] == 4'b0000) && m_axis_rx_tuser[2+BAR_INDEX] &&
                  !m_axis_rx_tuser[1];

  // State register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= S_HDR0;
    else             state <= next_state;
  end

  // Next-state logic; drop flags a TLP being discarded on this beat
  always_comb begin
    next_state = state;
    drop       = 1'b0;
    unique case (state)
      S_HDR0: if (beat) begin
        if (m_axis_rx_tlast) begin
          drop = 1'b1;
        end else if (hdr_ok) begin
          next_state = S_HDR1;
        end else begin
          drop       = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_HDR1: if (beat) begin
        if (is_4dw_q && is_wr_q) begin
          // MWr64 needs a further payload beat; ending here is malformed
          if (m_axis_rx_tlast) drop = 1'b1;
          next_state = m_axis_rx_tlast ? S_HDR0 : S_DATA;
        end else if (m_axis_rx_tlast) begin
          next_state = is_wr_q ? S_WR : S_RD;
        end else begin
          drop       = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_DATA: if (beat) begin
        if (m_axis_rx_tlast) begin
          next_state = S_WR;
        end else begin
          drop       = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: if (beat && m_axis_rx_tlast) next_state = S_HDR0;
      S_WR:    if (wr_ready) next_state = S_HDR0;
      S_RD:    if (rd_ready) next_state = S_HDR0;
      default: next_state = S_HDR0;
    endcase
  end

  // Output decode straight from the state register
  always_comb begin
    m_axis_rx_tready = 1'b1;
    rx_np_ok         = 1'b1;
    wr_valid         = 1'b0;
    rd_valid         = 1'b0;
    unique case (state)
      S_WR: begin
        m_axis_rx_tready = 1'b0;
        wr_valid         = 1'b1;
      end
      S_RD: begin
        m_axis_rx_tready = 1'b0;
        rx_np_ok         = 1'b0;
        rd_valid         = 1'b1;
      end
      default: ;
    endcase
  end

  // Header / address / payload capture. Nothing is captured while a request
  // is presented because tready is low then, so fields stay stable.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      is_wr_q  <= 1'b0;
      is_4dw_q <= 1'b0;
      req_id_q <= '0;
      tag_q    <= '0;
      tc_q     <= '0;
      attr_q   <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if (beat) begin
      unique case (state)
        S_HDR0: begin
          is_wr_q  <= dw0[30];
          is_4dw_q <= dw0[29];
          tc_q     <= dw0[22:20];
          attr_q   <= dw0[13:12];
          req_id_q <= dw1[31:16];
          tag_q    <= dw1[15:8];
          be_q     <= dw1[3:0];
        end
        S_HDR1: begin
          // 3DW: DW2 = address, DW3 = payload. 4DW: DW2 = addr hi (dropped),
          // DW3 = addr lo; payload arrives in S_DATA.
          addr_q <= is_4dw_q ? dw1 : dw0;
          data_q <= dw1;
        end
        S_DATA:  data_q <= dw0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n)                drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
  end

  always_comb begin
    be_low = 2'd0;
    if      (be_q[0]) be_low = 2'd0;
    else if (be_q[1]) be_low = 2'd1;
    else if (be_q[2]) be_low = 2'd2;
    else if (be_q[3]) be_low = 2'd3;
  end

  assign wr_addr       = addr_q[ADDR_W+1:2];
  assign wr_data       = data_q;
  assign wr_be         = be_q;
  assign rd_addr       = addr_q[ADDR_W+1:2];
  assign rd_req_id     = req_id_q;
  assign rd_tag        = tag_q;
  assign rd_tc         = tc_q;
  assign rd_attr       = attr_q;
  assign rd_be         = be_q;
  assign rd_lower_addr = {addr_q[6:2], be_low};

  logic unused_inputs;
  assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tuser, addr_q};

endmodule
